// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Shares one external memory port between the i$ refill path and the
//   d$ refill/write-back path. One line-sized transaction at a time: grant,
//   one-cycle memory strobe, wait for memory completion, then a one-cycle
//   done pulse (with read data) back to the granted cache.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   i_req_i, i_addr_i      i$ line read request and address
//   i_rdata_o, i_done_o    line and completion pulse back to i$
//   d_req_i, d_rw_i        d$ request, direction (0 read, 1 write-back)
//   d_addr_i, d_wdata_i    d$ line address and write-back line
//   d_rdata_o, d_done_o    line and completion pulse back to d$
//   mem_strobe_o           one-cycle transaction start to memory
//   mem_rw_o, mem_addr_o,
//   mem_wdata_o            transaction attributes, zero while idle
//   mem_rdata_i, mem_done_i memory read data and completion pulse
//   arb_S_o                current arbiter state (profiler)
//   gnt_o                  current or last grant: 0 i$, 1 d$
//
// Handshake: a requester raises req and holds it until its done pulse.
// Requests are sampled only in the idle state, and mem_done_i is honoured
// only while waiting, so anything seen in other states is ignored.
module cache_mem_arbiter #(
  parameter int XLEN   = 32,
  parameter int CLSIZE = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [XLEN-1:0]   i_addr_i,
  output logic [CLSIZE-1:0] i_rdata_o,
  output logic              i_done_o,
  input  logic              d_req_i,
  input  logic              d_rw_i,
  input  logic [XLEN-1:0]   d_addr_i,
  input  logic [CLSIZE-1:0] d_wdata_i,
  output logic [CLSIZE-1:0] d_rdata_o,
  output logic              d_done_o,
  output logic              mem_strobe_o,
  output logic              mem_rw_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [CLSIZE-1:0] mem_wdata_o,
  input  logic [CLSIZE-1:0] mem_rdata_i,
  input  logic              mem_done_i,
  output logic [1:0]        arb_S_o,
  output logic              gnt_o
);

  typedef enum logic [1:0] {
    A_IDLE  = 2'd0,
    A_ISSUE = 2'd1,
    A_WAIT  = 2'd2,
    A_DONE  = 2'd3
  } arb_state_t;

  arb_state_t state, state_next;

  // last_gnt doubles as the grant of the transaction in flight: it is
  // updated on the grant edge and held until the next grant.
  logic              last_gnt;
  logic              grant_next;
  logic              rw_q;
  logic [XLEN-1:0]   addr_q;
  logic [CLSIZE-1:0] wdata_q;
  logic [CLSIZE-1:0] line_q;
  logic              grant_edge;
  logic              active;
  logic              in_done;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= A_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    grant_next = last_gnt;
    case (state)
      A_IDLE: begin
        if (i_req_i || d_req_i) begin
          state_next = A_ISSUE;
          // On a tie the side that did not win last time goes next.
          if (i_req_i && d_req_i) begin
            grant_next = ~last_gnt;
          end else begin
            grant_next = d_req_i;
          end
        end
      end
      A_ISSUE: state_next = A_WAIT;
      A_WAIT: begin
        if (mem_done_i) begin
          state_next = A_DONE;
        end
      end
      A_DONE:  state_next = A_IDLE;
      default: state_next = A_IDLE;
    endcase
  end

  assign grant_edge = (state == A_IDLE) && (state_next == A_ISSUE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_gnt <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      line_q   <= '0;
    end else begin
      if (grant_edge) begin
        last_gnt <= grant_next;
        rw_q     <= grant_next ? d_rw_i : 1'b0;
        addr_q   <= grant_next ? d_addr_i : i_addr_i;
        wdata_q  <= grant_next ? d_wdata_i : '0;
      end
      if ((state == A_WAIT) && mem_done_i) begin
        line_q <= mem_rdata_i;
      end
    end
  end

  assign active  = (state != A_IDLE);
  assign in_done = (state == A_DONE);

  assign mem_strobe_o = (state == A_ISSUE);
  assign mem_rw_o     = active & rw_q;
  assign mem_addr_o   = active ? addr_q : '0;
  assign mem_wdata_o  = active ? wdata_q : '0;

  assign i_done_o  = in_done & ~last_gnt;
  assign d_done_o  = in_done & last_gnt;
  // i$ only ever reads; a d$ write-back returns an all-zero line.
  assign i_rdata_o = i_done_o ? line_q : '0;
  assign d_rdata_o = (d_done_o && !rw_q) ? line_q : '0;

  assign arb_S_o = state;
  assign gnt_o   = last_gnt;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
`timescale 1ns/1ps
module tb_cache_mem_arbiter;

  localparam int XLEN   = 32;
  localparam int CLSIZE = 128;
  localparam int CW     = 192;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              i_req_i;
  logic [XLEN-1:0]   i_addr_i;
  logic [CLSIZE-1:0] i_rdata_o;
  logic              i_done_o;
  logic              d_req_i;
  logic              d_rw_i;
  logic [XLEN-1:0]   d_addr_i;
  logic [CLSIZE-1:0] d_wdata_i;
  logic [CLSIZE-1:0] d_rdata_o;
  logic              d_done_o;
  logic              mem_strobe_o;
  logic              mem_rw_o;
  logic [XLEN-1:0]   mem_addr_o;
  logic [CLSIZE-1:0] mem_wdata_o;
  logic [CLSIZE-1:0] mem_rdata_i;
  logic              mem_done_i;
  logic [1:0]        arb_S_o;
  logic              gnt_o;

  cache_mem_arbiter #(.XLEN(XLEN), .CLSIZE(CLSIZE)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_rdata_o(i_rdata_o), .i_done_o(i_done_o),
    .d_req_i(d_req_i), .d_rw_i(d_rw_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_rdata_o(d_rdata_o), .d_done_o(d_done_o),
    .mem_strobe_o(mem_strobe_o), .mem_rw_o(mem_rw_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_done_i(mem_done_i),
    .arb_S_o(arb_S_o), .gnt_o(gnt_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [CLSIZE:0]          done_exp_q[$];   // {side, rdata}
  logic [1+XLEN+CLSIZE-1:0] mem_exp_q[$];    // {rw, addr, wdata (writes only)}
  logic [CLSIZE-1:0]        rd_q[$];
  int                       delay_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int hold_left = 0;
  int lat_req_cyc = -1;
  int done_drive_cyc = -1;
  bit resp_en = 1'b0;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, arb_S_o, 0);
    check({tag, "_gnt"}, gnt_o, 0);
    check({tag, "_done"}, {i_done_o, d_done_o}, 0);
    check({tag, "_rdata"}, i_rdata_o | d_rdata_o, 0);
    check({tag, "_membus"}, {mem_strobe_o, mem_rw_o, mem_addr_o, mem_wdata_o}, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_exp(input logic side, input logic rw, input logic [XLEN-1:0] addr,
                          input logic [CLSIZE-1:0] wd, input logic [CLSIZE-1:0] rd, input int dly);
    logic rw_e;
    rw_e = side & rw;
    mem_exp_q.push_back({rw_e, addr, rw_e ? wd : {CLSIZE{1'b0}}});
    rd_q.push_back(rd);
    delay_q.push_back(dly);
    done_exp_q.push_back({side, rw_e ? {CLSIZE{1'b0}} : rd});
  endtask

  task automatic issue(input logic side, input logic rw, input logic [XLEN-1:0] addr,
                       input logic [CLSIZE-1:0] wd, input logic [CLSIZE-1:0] rd, input int dly);
    push_exp(side, rw, addr, wd, rd, dly);
    @(negedge clk_i);
    if (side) begin
      d_rw_i = rw; d_addr_i = addr; d_wdata_i = wd; d_req_i = 1'b1;
    end else begin
      i_addr_i = addr; i_req_i = 1'b1;
    end
    lat_req_cyc = cyc;
  endtask

  task automatic wait_dones(input int target, input int budget);
    int b;
    b = budget;
    while (done_cnt < target && b > 0) begin
      @(negedge clk_i);
      b--;
    end
    if (done_cnt < target) check("timeout_done", done_cnt, target);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // ---------------- memory responder ----------------
  initial begin
    logic [1+XLEN+CLSIZE-1:0] m;
    int d;
    forever begin
      @(negedge clk_i);
      if (resp_en && !rst_i && mem_strobe_o) begin
        if (lat_req_cyc >= 0) begin
          check("strobe_latency", cyc, lat_req_cyc + 1);
          lat_req_cyc = -1;
        end
        if (mem_exp_q.size() == 0 || rd_q.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          m = mem_exp_q.pop_front();
          check("mem_req", {mem_rw_o, mem_addr_o, mem_rw_o ? mem_wdata_o : {CLSIZE{1'b0}}}, m);
          d = delay_q.pop_front();
          for (int k = 0; k < d; k++) begin
            @(negedge clk_i);
            if (k == 0) check("strobe_one_cycle", mem_strobe_o, 0);
          end
          mem_rdata_i = rd_q.pop_front();
          mem_done_i = 1'b1;
          done_drive_cyc = cyc;
          @(negedge clk_i);
          mem_done_i = 1'b0;
          mem_rdata_i = '0;
        end
      end
    end
  end

  // ---------------- done monitor / scoreboard ----------------
  initial begin
    logic [CLSIZE:0] e;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if (arb_S_o == 2'd0)
          check("idle_bus_zero", {mem_strobe_o, mem_rw_o, mem_addr_o, mem_wdata_o}, 0);
        if (i_done_o || d_done_o) begin
          check("done_onehot", i_done_o & d_done_o, 0);
          if (done_exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = done_exp_q.pop_front();
            check("done_side", d_done_o, e[CLSIZE]);
            check("done_rdata", d_done_o ? d_rdata_o : i_rdata_o, e[CLSIZE-1:0]);
            check("other_rdata_zero", d_done_o ? i_rdata_o : d_rdata_o, 0);
          end
          if (done_drive_cyc >= 0) check("done_latency", cyc, done_drive_cyc + 1);
          done_drive_cyc = -1;
          done_cnt++;
          if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) begin
              i_req_i = 1'b0;
              d_req_i = 1'b0;
            end
          end else if (i_done_o) begin
            i_req_i = 1'b0;
          end else begin
            d_req_i = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- global watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [CLSIZE-1:0] line;
    logic [CLSIZE-1:0] rdv[4];
    int tgt;

    rst_i = 1'b1; i_req_i = 0; i_addr_i = '0; d_req_i = 0; d_rw_i = 0;
    d_addr_i = '0; d_wdata_i = '0; mem_rdata_i = '0; mem_done_i = 0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    check_all_zero("reset");
    resp_en = 1'b1;

    // Single i$ read, memory answers 5 cycles after the strobe.
    line = 128'hDEAD0000_11112222_33334444_0000BEEF;
    tgt = done_cnt + 1;
    issue(1'b0, 1'b0, 32'h0000_1000, '0, line, 5);
    wait_dones(tgt, 50);

    // d$ write-back, memory answers 2 cycles after the strobe.
    tgt = done_cnt + 1;
    issue(1'b1, 1'b1, 32'h0000_2000, 128'h12345678_9ABCDEF0_0FEDCBA9_87654321,
          128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 2);
    wait_dones(tgt, 50);

    // Random single transactions, minimum and longer memory latencies.
    for (int t = 0; t < 6; t++) begin
      logic s, w;
      s = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      line = {$urandom, $urandom, $urandom, $urandom};
      tgt = done_cnt + 1;
      issue(s, w, {$urandom_range(0, 32'hFFFF), 4'h0}, {$urandom, $urandom, $urandom, $urandom},
            line, (t == 0) ? 1 : $urandom_range(1, 6));
      wait_dones(tgt, 60);
    end

    // Tie after reset: both held for 4 transactions, grant order d,i,d,i.
    do_reset();
    check_all_zero("reset2");
    for (int k = 0; k < 4; k++) rdv[k] = {$urandom, $urandom, $urandom, $urandom};
    push_exp(1'b1, 1'b0, 32'h0000_3000, '0, rdv[0], $urandom_range(1, 5));
    push_exp(1'b0, 1'b0, 32'h0000_4000, '0, rdv[1], $urandom_range(1, 5));
    push_exp(1'b1, 1'b0, 32'h0000_3000, '0, rdv[2], $urandom_range(1, 5));
    push_exp(1'b0, 1'b0, 32'h0000_4000, '0, rdv[3], $urandom_range(1, 5));
    tgt = done_cnt + 4;
    hold_left = 4;
    @(negedge clk_i);
    d_rw_i = 1'b0; d_addr_i = 32'h0000_3000; i_addr_i = 32'h0000_4000;
    d_req_i = 1'b1; i_req_i = 1'b1;
    wait_dones(tgt, 200);

    // Spurious completion in idle and early completion in issue.
    resp_en = 1'b0;
    @(negedge clk_i);
    mem_done_i = 1'b1; mem_rdata_i = {4{32'hBAD0BAD0}};
    @(negedge clk_i);
    mem_done_i = 1'b0;
    check("spurious_idle_state", arb_S_o, 0);
    d_rw_i = 1'b0; d_addr_i = 32'h0000_5000; d_req_i = 1'b1;
    @(negedge clk_i);
    check("early_issue_state", arb_S_o, 1);
    check("early_strobe", {mem_strobe_o, mem_addr_o}, {1'b1, 32'h0000_5000});
    mem_done_i = 1'b1;
    @(negedge clk_i);
    mem_done_i = 1'b0;
    check("early_ignored_state", arb_S_o, 2);
    repeat (2) @(negedge clk_i);
    check("still_waiting", arb_S_o, 2);
    line = {4{32'hC0FFEE11}};
    done_exp_q.push_back({1'b1, line});
    tgt = done_cnt + 1;
    mem_done_i = 1'b1; mem_rdata_i = line; done_drive_cyc = cyc;
    @(negedge clk_i);
    mem_done_i = 1'b0; mem_rdata_i = '0;
    check("late_done_state", arb_S_o, 3);
    @(negedge clk_i);
    check("back_to_idle", arb_S_o, 0);
    if (done_cnt < tgt) check("early_done_count", done_cnt, tgt);

    // Reset during A_Wait aborts a d$ write-back.
    @(negedge clk_i);
    d_rw_i = 1'b1; d_addr_i = 32'h0000_6000; d_wdata_i = {4{32'h66666666}}; d_req_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("abort_pre_state", arb_S_o, 2);
    check("abort_pre_gnt", gnt_o, 1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    d_req_i = 1'b0;
    check_all_zero("rst_mid");
    mem_done_i = 1'b1; mem_rdata_i = {4{32'h77777777}};
    @(negedge clk_i);
    mem_done_i = 1'b0; mem_rdata_i = '0;
    check("abort_late_done_state", arb_S_o, 0);
    @(negedge clk_i);
    check("abort_still_idle", arb_S_o, 0);

    // Next tie after reset must go to d$.
    resp_en = 1'b1;
    push_exp(1'b1, 1'b0, 32'h0000_7000, '0, {4{32'h0A0B0C0D}}, 3);
    tgt = done_cnt + 1;
    hold_left = 1;
    @(negedge clk_i);
    d_rw_i = 1'b0; d_addr_i = 32'h0000_7000; i_addr_i = 32'h0000_8000;
    d_req_i = 1'b1; i_req_i = 1'b1;
    wait_dones(tgt, 50);
    repeat (4) @(negedge clk_i);

    check("done_q_empty", done_exp_q.size(), 0);
    check("mem_q_empty", mem_exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
